alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller that sequences the 8-bit ALU datapath for the mini CPU.
- Accepts one command at a time over a valid/ready handshake.
- Reads two operands from an internal 4x8 register file and drives them onto the ALU operand buses.
- Selects the ALU output by opcode, then writes the result back and updates flags; sits between the instruction decoder and the ALU.

Parameters:
- NREGS, 4, number of register-file entries; register address width is clog2(NREGS).
- WIDTH, 8, datapath width; must match the ALU.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode, see Behaviour.
- cmd_rd  in  2  destination register.
- cmd_rs1  in  2  source register driven to the ALU R1 operand.
- cmd_rs2  in  2  source register driven to the ALU R2 operand.
- cmd_imm  in  8  immediate value for LOAD.
- alu_r1  out  8  ALU operand R1, registered.
- alu_r2  out  8  ALU operand R2, registered.
- alu_add, alu_mul2, alu_div2, alu_and, alu_or, alu_cmp  in  8 each  ALU result buses.
- alu_add_ovf, alu_mul2_ovf  in  1 each  ALU overflow outputs.
- result  out  8  last value computed (held).
- ovf_flag  out  1  sticky-until-next-arith overflow flag.
- cmp_result  out  8  last ALU Compare byte captured.
- done  out  1  one-cycle pulse when a command retires.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge.
- Reset values: FSM=IDLE, cmd_ready=1, done=0, result=0, ovf_flag=0, cmp_result=0, alu_r1=alu_r2=0, all register-file entries=0.
- Opcodes:
  - 000 NOP
  - 001 ADD: rs1+rs2
  - 010 MUL2: rs2<<1
  - 011 DIV2: rs2>>1
  - 100 AND
  - 101 OR
  - 110 CMP
  - 111 LOAD imm
- FSM IDLE -> READ -> EXEC -> WRITE -> IDLE.
- IDLE: cmd_ready=1. On cmd_valid&cmd_ready, latch op/rd/rs1/rs2/imm and go to READ.
- READ: cmd_ready=0. alu_r1<=rf[rs1], alu_r2<=rf[rs2]. Go to EXEC.
- EXEC: the ALU is combinational and operands are stable. Capture the selected bus into a result register.
  - ADD and MUL2 also capture the matching overflow into ovf_flag.
  - All other opcodes leave ovf_flag unchanged.
  - CMP captures alu_cmp into cmp_result.
  - LOAD selects cmd_imm.
- WRITE: rf[rd]<=result for ADD, MUL2, DIV2, AND, OR and LOAD. NOP and CMP do not write. done=1 for exactly this cycle. Next state is IDLE.
- Latency: handshake at cycle N; done is high in cycle N+3; next accept is possible at N+4. Every opcode has the same latency.
- cmd_valid while cmd_ready=0 is ignored; the command is not queued.
- rd equal to rs1 or rs2: operands are read before the write, so the old value is used.
- Reset mid-command: abort immediately. No done pulse and no register-file write.
- Arithmetic is modulo 2^WIDTH; the sequencer never widens results.
- Unused opcode encodings: none; all 8 are defined.

Optional Feature:
- Macro ALU_SAT_EN.
- Defined: ADD or MUL2 with overflow=1 writes 0xFF into result and the register file instead of the wrapped value. ovf_flag is still set.
- Undefined: the wrapped value is written.

Decomposition:
- Shared package alu_seq_pkg holds:
  - opcode localparams OP_NOP..OP_LOAD
  - state encoding ST_IDLE, ST_READ, ST_EXEC, ST_WRITE
  - WIDTH and NREGS defaults
- One natural sub-module, alu_seq_regfile: NREGS x WIDTH, two async read ports, one sync write port, sync reset-to-zero.

Test Plan:
- Reset mid-command: LOAD r3,0x55 accepted, reset asserted in EXEC -> no done, rf[3]=0x00, cmd_ready=1 on the next cycle.
- Basic add: LOAD r0,200; LOAD r1,100; ADD r2,r0,r1 -> done at accept+3, result=0x2C, ovf_flag=1, rf[2]=0x2C (0xFF with ALU_SAT_EN).
- Shifts: LOAD r1,0x81; MUL2 r2,-,r1 -> result=0x02, ovf_flag=1. Then DIV2 r3,-,r1 -> rf[3]=0x40, ovf_flag still 1.
- Logic and compare: LOAD r0,0xF0; LOAD r1,0x3C; AND r2 -> 0x30; OR r3 -> 0xFC; CMP r0,r1 -> cmp_result equals the ALU Compare output for (0xF0,0x3C), and rf is unchanged.
- Handshake: hold cmd_valid high continuously with 3 back-to-back commands -> exactly one accept every 4 cycles, 3 done pulses, no command dropped or duplicated.
- Hazard: ADD r0,r0,r0 with r0=0x07 -> rf[0]=0x0E. NOP -> done pulses and no register or flag changes.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state encoding and default sizes.
package alu_seq_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREGS = 4;

    localparam logic [2:0] OP_NOP  = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_MUL2 = 3'b010;
    localparam logic [2:0] OP_DIV2 = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_LOAD = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_EXEC,
        ST_WRITE
    } state_e;

    // NOP and CMP retire without touching the register file.
    function automatic logic op_writes_rf(input logic [2:0] op);
        return !((op == OP_NOP) || (op == OP_CMP));
    endfunction

endpackage

// File: rtl/alu_seq_regfile.sv
// Register file for the ALU sequencer: two asynchronous read ports, one synchronous
// write port, synchronous reset clearing every entry to zero.
module alu_seq_regfile #(
    parameter int NREGS = 4,
    parameter int WIDTH = 8,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic [AW-1:0]    raddr1_i,
    output logic [WIDTH-1:0] rdata1_o,
    input  logic [AW-1:0]    raddr2_i,
    output logic [WIDTH-1:0] rdata2_o,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i
);

    logic [WIDTH-1:0] rf_q [NREGS];

    assign rdata1_o = rf_q[raddr1_i];
    assign rdata2_o = rf_q[raddr2_i];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle controller sequencing the external ALU: IDLE -> READ -> EXEC -> WRITE.
// Optional macro ALU_SAT_EN saturates overflowing ADD/MUL2 results to all ones.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREGS = DEF_NREGS,
    parameter int WIDTH = DEF_WIDTH,
    localparam int AW = $clog2(NREGS)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [2:0]       cmd_op_i,
    input  logic [AW-1:0]    cmd_rd_i,
    input  logic [AW-1:0]    cmd_rs1_i,
    input  logic [AW-1:0]    cmd_rs2_i,
    input  logic [WIDTH-1:0] cmd_imm_i,
    output logic [WIDTH-1:0] alu_r1_o,
    output logic [WIDTH-1:0] alu_r2_o,
    input  logic [WIDTH-1:0] alu_add_i,
    input  logic [WIDTH-1:0] alu_mul2_i,
    input  logic [WIDTH-1:0] alu_div2_i,
    input  logic [WIDTH-1:0] alu_and_i,
    input  logic [WIDTH-1:0] alu_or_i,
    input  logic [WIDTH-1:0] alu_cmp_i,
    input  logic             alu_add_ovf_i,
    input  logic             alu_mul2_ovf_i,
    output logic [WIDTH-1:0] result_o,
    output logic             ovf_flag_o,
    output logic [WIDTH-1:0] cmp_result_o,
    output logic             done_o
);

`ifdef ALU_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    state_e           state_q;
    logic             cmd_ready_q;
    logic             done_q;
    logic [2:0]       op_q;
    logic [AW-1:0]    rd_q;
    logic [AW-1:0]    rs1_q;
    logic [AW-1:0]    rs2_q;
    logic [WIDTH-1:0] imm_q;
    logic [WIDTH-1:0] r1_q;
    logic [WIDTH-1:0] r2_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [WIDTH-1:0] cmp_q;
    logic [WIDTH-1:0] cmp_d;
    logic [WIDTH-1:0] rdata1;
    logic [WIDTH-1:0] rdata2;
    logic             rf_we;

    // Writeback happens in WRITE from the result captured in EXEC, so operands
    // read in READ always see the pre-write value even when rd aliases rs1/rs2.
    assign rf_we = (state_q == ST_WRITE) && op_writes_rf(op_q);

    alu_seq_regfile #(
        .NREGS(NREGS),
        .WIDTH(WIDTH)
    ) u_rf (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .raddr1_i (rs1_q),
        .rdata1_o (rdata1),
        .raddr2_i (rs2_q),
        .rdata2_o (rdata2),
        .we_i     (rf_we),
        .waddr_i  (rd_q),
        .wdata_i  (result_q)
    );

    always_comb begin
        result_d = result_q;
        ovf_d    = ovf_q;
        cmp_d    = cmp_q;
        case (op_q)
            OP_ADD: begin
                result_d = alu_add_i;
                ovf_d    = alu_add_ovf_i;
            end
            OP_MUL2: begin
                result_d = alu_mul2_i;
                ovf_d    = alu_mul2_ovf_i;
            end
            OP_DIV2: result_d = alu_div2_i;
            OP_AND:  result_d = alu_and_i;
            OP_OR:   result_d = alu_or_i;
            OP_CMP: begin
                result_d = alu_cmp_i;
                cmp_d    = alu_cmp_i;
            end
            OP_LOAD: result_d = imm_q;
            default: result_d = result_q;
        endcase
        if (SatEn && ((op_q == OP_ADD) || (op_q == OP_MUL2)) && ovf_d) begin
            result_d = '1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            done_q      <= 1'b0;
            op_q        <= OP_NOP;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            imm_q       <= '0;
            r1_q        <= '0;
            r2_q        <= '0;
            result_q    <= '0;
            ovf_q       <= 1'b0;
            cmp_q       <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (cmd_valid_i && cmd_ready_q) begin
                        op_q        <= cmd_op_i;
                        rd_q        <= cmd_rd_i;
                        rs1_q       <= cmd_rs1_i;
                        rs2_q       <= cmd_rs2_i;
                        imm_q       <= cmd_imm_i;
                        cmd_ready_q <= 1'b0;
                        state_q     <= ST_READ;
                    end
                end
                ST_READ: begin
                    r1_q    <= rdata1;
                    r2_q    <= rdata2;
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q <= result_d;
                    ovf_q    <= ovf_d;
                    cmp_q    <= cmp_d;
                    done_q   <= 1'b1;
                    state_q  <= ST_WRITE;
                end
                ST_WRITE: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
                default: begin
                    cmd_ready_q <= 1'b1;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o  = cmd_ready_q;
    assign done_o       = done_q;
    assign alu_r1_o     = r1_q;
    assign alu_r2_o     = r2_q;
    assign result_o     = result_q;
    assign ovf_flag_o   = ovf_q;
    assign cmp_result_o = cmp_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: behavioural ALU plus a command-level reference model.
module tb_alu_sequencer;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       cmd_valid_i;
    logic       cmd_ready_o;
    logic [2:0] cmd_op_i;
    logic [1:0] cmd_rd_i, cmd_rs1_i, cmd_rs2_i;
    logic [7:0] cmd_imm_i;
    logic [7:0] alu_r1_o, alu_r2_o;
    logic [7:0] alu_add_i, alu_mul2_i, alu_div2_i, alu_and_i, alu_or_i, alu_cmp_i;
    logic       alu_add_ovf_i, alu_mul2_ovf_i;
    logic [7:0] result_o, cmp_result_o;
    logic       ovf_flag_o, done_o;

`ifdef ALU_SAT_EN
    localparam bit SatEn = 1'b1;
`else
    localparam bit SatEn = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int doneCount = 0;
    int expDone = 0;
    int lastAccept = 0;
    int prevAccept = 0;

    logic [7:0] mrf [4];
    logic [7:0] mResult;
    logic       mOvf;
    logic [7:0] mCmp;

    always #5 clk_i = ~clk_i;

    // Behavioural ALU: compare byte is {gt, eq, lt} in the low bits.
    function automatic logic [7:0] aluCmp(input logic [7:0] a, input logic [7:0] b);
        return {5'b0, (a > b), (a == b), (a < b)};
    endfunction

    assign {alu_add_ovf_i, alu_add_i} = {1'b0, alu_r1_o} + {1'b0, alu_r2_o};
    assign alu_mul2_i     = {alu_r2_o[6:0], 1'b0};
    assign alu_mul2_ovf_i = alu_r2_o[7];
    assign alu_div2_i     = {1'b0, alu_r2_o[7:1]};
    assign alu_and_i      = alu_r1_o & alu_r2_o;
    assign alu_or_i       = alu_r1_o | alu_r2_o;
    assign alu_cmp_i      = aluCmp(alu_r1_o, alu_r2_o);

    alu_sequencer dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .cmd_valid_i    (cmd_valid_i),
        .cmd_ready_o    (cmd_ready_o),
        .cmd_op_i       (cmd_op_i),
        .cmd_rd_i       (cmd_rd_i),
        .cmd_rs1_i      (cmd_rs1_i),
        .cmd_rs2_i      (cmd_rs2_i),
        .cmd_imm_i      (cmd_imm_i),
        .alu_r1_o       (alu_r1_o),
        .alu_r2_o       (alu_r2_o),
        .alu_add_i      (alu_add_i),
        .alu_mul2_i     (alu_mul2_i),
        .alu_div2_i     (alu_div2_i),
        .alu_and_i      (alu_and_i),
        .alu_or_i       (alu_or_i),
        .alu_cmp_i      (alu_cmp_i),
        .alu_add_ovf_i  (alu_add_ovf_i),
        .alu_mul2_ovf_i (alu_mul2_ovf_i),
        .result_o       (result_o),
        .ovf_flag_o     (ovf_flag_o),
        .cmp_result_o   (cmp_result_o),
        .done_o         (done_o)
    );

    // Handshake and retirement monitor sampled at the active edge (pre-update values).
    always @(posedge clk_i) begin
        if (!reset_i && cmd_valid_i && cmd_ready_o) lastAccept = cycle;
        if (done_o) doneCount++;
        cycle++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 4; i++) mrf[i] = 8'h00;
        mResult = 8'h00;
        mOvf    = 1'b0;
        mCmp    = 8'h00;
    endtask

    // Command-level reference: what one retired command does to the architectural state.
    task automatic modelExec(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                             input logic [1:0] rs2, input logic [7:0] imm);
        int a, b, v;
        bit wr;
        a  = mrf[rs1];
        b  = mrf[rs2];
        wr = 1'b1;
        case (op)
            3'd1: begin v = a + b; mOvf = (v > 255); end
            3'd2: begin v = b * 2; mOvf = (v > 255); end
            3'd3: v = b / 2;
            3'd4: v = a & b;
            3'd5: v = a | b;
            3'd6: begin v = aluCmp(a[7:0], b[7:0]); mCmp = v[7:0]; wr = 1'b0; end
            3'd7: v = imm;
            default: begin v = mResult; wr = 1'b0; end
        endcase
        if (SatEn && (op == 3'd1 || op == 3'd2) && v > 255) v = 255;
        mResult = v[7:0];
        if (wr) mrf[rd] = v[7:0];
    endtask

    task automatic checkRf(input string tag);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_rf%0d", tag, i), dut.u_rf.rf_q[i], mrf[i]);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge of cycle N+4.
    task automatic applyStimulus(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                                 input logic [1:0] rs2, input logic [7:0] imm,
                                 input bit keep, input bit chained);
        int waitCycles;
        cmd_valid_i = 1'b1;
        cmd_op_i    = op;
        cmd_rd_i    = rd;
        cmd_rs1_i   = rs1;
        cmd_rs2_i   = rs2;
        cmd_imm_i   = imm;
        waitCycles  = 0;
        while (!cmd_ready_o && waitCycles < 8) begin
            @(negedge clk_i);
            waitCycles++;
        end
        if (!cmd_ready_o) begin
            checkOutput("accept_timeout", 32'd0, 32'd1);
            cmd_valid_i = 1'b0;
            return;
        end
        if (chained) checkOutput("accept_spacing", waitCycles, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        if (chained) checkOutput("accept_period", lastAccept - prevAccept, 4);
        prevAccept = lastAccept;
        if (!keep) cmd_valid_i = 1'b0;
        checkOutput("done_n1", done_o, 1'b0);
        checkOutput("ready_n1", cmd_ready_o, 1'b0);
        @(negedge clk_i);
        checkOutput("done_n2", done_o, 1'b0);
        @(negedge clk_i);
        modelExec(op, rd, rs1, rs2, imm);
        expDone++;
        checkOutput("done_n3", done_o, 1'b1);
        checkOutput("result", result_o, mResult);
        checkOutput("ovf_flag", ovf_flag_o, mOvf);
        checkOutput("cmp_result", cmp_result_o, mCmp);
        @(negedge clk_i);
        checkOutput("done_n4", done_o, 1'b0);
        checkOutput("ready_n4", cmd_ready_o, 1'b1);
        checkRf("wb");
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit prevKeep;
        bit keep;
        logic [2:0] rop;
        reset_i     = 1'b1;
        cmd_valid_i = 1'b0;
        cmd_op_i    = 3'd0;
        cmd_rd_i    = 2'd0;
        cmd_rs1_i   = 2'd0;
        cmd_rs2_i   = 2'd0;
        cmd_imm_i   = 8'd0;
        modelReset();
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;
        checkOutput("rst_ready", cmd_ready_o, 1'b1);
        checkOutput("rst_done", done_o, 1'b0);
        checkOutput("rst_result", result_o, 8'h00);
        checkOutput("rst_ovf", ovf_flag_o, 1'b0);
        checkOutput("rst_cmp", cmp_result_o, 8'h00);
        checkOutput("rst_r1", alu_r1_o, 8'h00);
        checkOutput("rst_r2", alu_r2_o, 8'h00);
        checkRf("rst");

        // Reset during EXEC of LOAD r3,0x55 aborts with no done and no write.
        applyStimulus(3'd7, 2'd0, 2'd0, 2'd0, 8'h12, 1'b0, 1'b0);
        cmd_valid_i = 1'b1; cmd_op_i = 3'd7; cmd_rd_i = 2'd3; cmd_imm_i = 8'h55;
        @(posedge clk_i);
        @(negedge clk_i);
        cmd_valid_i = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        @(negedge clk_i);
        reset_i = 1'b0;
        modelReset();
        checkOutput("abort_done", done_o, 1'b0);
        checkOutput("abort_ready", cmd_ready_o, 1'b1);
        checkOutput("abort_rf3", dut.u_rf.rf_q[3], 8'h00);
        @(negedge clk_i);
        checkOutput("abort_done_count", doneCount, expDone);
        checkRf("abort");

        // Basic add with overflow.
        applyStimulus(3'd7, 2'd0, 2'd0, 2'd0, 8'd200, 1'b0, 1'b0);
        applyStimulus(3'd7, 2'd1, 2'd0, 2'd0, 8'd100, 1'b0, 1'b0);
        applyStimulus(3'd1, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, 1'b0);
        checkOutput("add_result_const", result_o, SatEn ? 8'hFF : 8'h2C);
        checkOutput("add_ovf_const", ovf_flag_o, 1'b1);

        // Shifts: MUL2 overflows, DIV2 leaves the flag alone.
        applyStimulus(3'd7, 2'd1, 2'd0, 2'd0, 8'h81, 1'b0, 1'b0);
        applyStimulus(3'd2, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, 1'b0);
        checkOutput("mul2_result_const", result_o, SatEn ? 8'hFF : 8'h02);
        applyStimulus(3'd3, 2'd3, 2'd0, 2'd1, 8'd0, 1'b0, 1'b0);
        checkOutput("div2_rf3_const", dut.u_rf.rf_q[3], 8'h40);
        checkOutput("div2_ovf_const", ovf_flag_o, 1'b1);

        // Logic and compare.
        applyStimulus(3'd7, 2'd0, 2'd0, 2'd0, 8'hF0, 1'b0, 1'b0);
        applyStimulus(3'd7, 2'd1, 2'd0, 2'd0, 8'h3C, 1'b0, 1'b0);
        applyStimulus(3'd4, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, 1'b0);
        checkOutput("and_const", dut.u_rf.rf_q[2], 8'h30);
        applyStimulus(3'd5, 2'd3, 2'd0, 2'd1, 8'd0, 1'b0, 1'b0);
        checkOutput("or_const", dut.u_rf.rf_q[3], 8'hFC);
        applyStimulus(3'd6, 2'd2, 2'd0, 2'd1, 8'd0, 1'b0, 1'b0);
        checkOutput("cmp_const", cmp_result_o, 8'h04);

        // Back-to-back with cmd_valid held high.
        applyStimulus(3'd7, 2'd2, 2'd0, 2'd0, 8'h11, 1'b1, 1'b0);
        applyStimulus(3'd1, 2'd3, 2'd2, 2'd2, 8'd0, 1'b1, 1'b1);
        applyStimulus(3'd5, 2'd0, 2'd3, 2'd2, 8'd0, 1'b0, 1'b1);

        // Hazard and NOP.
        applyStimulus(3'd7, 2'd0, 2'd0, 2'd0, 8'h07, 1'b0, 1'b0);
        applyStimulus(3'd1, 2'd0, 2'd0, 2'd0, 8'd0, 1'b0, 1'b0);
        checkOutput("hazard_const", dut.u_rf.rf_q[0], 8'h0E);
        applyStimulus(3'd0, 2'd1, 2'd2, 2'd3, 8'hAA, 1'b0, 1'b0);

        // Randomized commands, occasionally chained with cmd_valid held.
        prevKeep = 1'b0;
        for (int n = 0; n < 60; n++) begin
            rop  = 3'($urandom_range(0, 7));
            keep = (n != 59) && ($urandom_range(0, 3) == 0);
            applyStimulus(rop, 2'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), keep, prevKeep);
            prevKeep = keep;
        end
        cmd_valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checkOutput("done_total", doneCount, expDone);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
